rr_arb_mux: RTL

Parametrised N:1 data multiplexer with built-in arbitration and a registered, valid/ready-handshaked output. It generalises the combinational select-driven mux into a block where the select is produced internally, either round-robin or fixed-priority, from per-channel valid requests. It sits between several producers and one consumer. It guarantees one transfer per cycle at full throughput and starvation-free service in round-robin mode.

---
 rtl/rr_arb_mux_pkg.sv | 17 +
 rtl/rr_arb_mux_arbiter.sv | 39 +++
 rtl/rr_arb_mux.sv | 75 +++++++
 3 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the rr_arb_mux arbitrated multiplexer and its bench.
package rr_arb_mux_pkg;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned DEF_W = 4;
    localparam int unsigned IDX_W = $clog2(DEF_N);

    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed priority from index 0.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned RR = 1,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0]  start;
    logic [N-1:0]   start_mask;
    logic [2*N-1:0] dbl;
    logic           found;

    // Lower half keeps only requests at or above start; upper half is the wrapped copy.
    always_comb begin
        start      = (RR != 0) ? ptr : '0;
        start_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            start_mask[i] = (i >= 32'(start));
        end
        dbl       = {req, req & start_mask};
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found     = 1'b1;
                grant_idx = (i < N) ? IW'(i) : IW'(i - N);
            end
        end
        any   = found;
        grant = found ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 arbitrated mux with a registered valid/ready output stage.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned N  = 4,
    parameter int unsigned RR = 1,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    input  logic [N-1:0][W-1:0] in_data,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [IW-1:0]       out_sel,
    input  logic                out_ready
);

    occ_t          state, state_next;
    logic [IW-1:0] ptr;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          any;
    logic          load;
    logic          xfer;

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign out_valid = (state == OCC_FULL);
    assign load      = !out_valid || out_ready;
    assign in_ready  = load ? grant : '0;
    // grant is a subset of in_valid, so any granted load is a transfer.
    assign xfer      = load && any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = any ? OCC_FULL : OCC_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            out_data <= in_data[grant_idx];
            out_sel  <= grant_idx;
            if (RR != 0) begin
                ptr <= IW'(wrap_inc(32'(grant_idx), N));
            end
        end
    end

endmodule
